uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an integrated baud divider, optional parity, 1 or 2 stop bits and a small input FIFO behind a valid/ready interface. It sits between the FPGA-side command/data logic and the ESP8266 RX pin. Frames are sent back-to-back with no idle gap while data is queued.

## Interface
- DATA_WIDTH, 8: data bits per frame, legal range 5..9.
- STOP_BITS, 1: stop bits, 1 or 2.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- CLKS_PER_BIT, 434: clk cycles per bit (50 MHz / 115200); must be ≥ 2.
- FIFO_DEPTH, 4: input FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- s_data  in  DATA_WIDTH  word to transmit.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO can accept; equals !full.
- tx  out  1  serial line, idle high.
- tx_busy  out  1  high from frame start until the last stop bit ends with FIFO empty.
- tx_done  out  1  one-cycle pulse on the final clk of each frame's last stop bit.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Push: s_valid && s_ready at a rising edge writes s_data. When full, s_ready = 0 even if a pop happens in the same cycle; no data is lost or overwritten.
- Simultaneous push and pop when not full: count unchanged, both take effect.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty: pop the head into the shift register, clear the bit counter and the baud counter.
  - START → DATA after one bit time.
  - DATA → PARITY after DATA_WIDTH bits if PARITY != 0, else → STOP.
  - PARITY → STOP after one bit time.
  - STOP → IDLE after STOP_BITS bit times if the FIFO is empty. If the FIFO is non-empty, STOP → START directly, popping in that same cycle.
- Bit time: the baud counter counts 0..CLKS_PER_BIT-1 and restarts at every frame start. Each bit holds tx for exactly CLKS_PER_BIT cycles.
- Line levels: data is sent LSB first. Start bit is 0; stop bits are 1.
- Parity bit: even parity sends the XOR of the data bits; odd parity sends its inverse.
- Frame length is (1 + DATA_WIDTH + (PARITY != 0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Illegal parameter values are rejected at elaboration.

## Timing
- Reset values (immediate and asynchronous):
  - tx = 1, tx_busy = 0, tx_done = 0, s_ready = 1, fifo_count = 0.
  - FIFO empty, FSM in IDLE.
- Reset mid-frame aborts the frame; tx returns high at once.
- All outputs are registered, except s_ready and fifo_count, which are decoded from registered pointers.
- Latency, idle and empty: word accepted at edge E; FIFO non-empty after E; pop and state = START at edge E+1; tx = 0 and tx_busy = 1 from edge E+1.
- Back-to-back: the next start bit begins on the cycle immediately after the last stop-bit cycle, with zero idle cycles.
- tx_busy deasserts together with the transition to IDLE, on the same edge as tx_done falls.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty is derived from an extra pointer MSB.

## Structure
- Shared package uart_pkg holds:
  - PARITY_NONE/ODD/EVEN constants;
  - the FSM state typedef (3-bit);
  - the default CLKS_PER_BIT constant, shared with the future receiver.
- One sub-module: uart_sync_fifo (parameters WIDTH, DEPTH). It provides push/pop/full/empty/count and is reusable by the RX side.
- Baud counter, FSM and shift register stay in the top module.

## Test plan
- Case 1, 0xA5 no parity. Setup: DATA_WIDTH=8, PARITY=0, STOP_BITS=1, CLKS_PER_BIT=4; push 0xA5 into idle. Expected:
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, 40 cycles total;
  - tx_done pulses once at cycle 40; tx_busy then drops.
- Case 2, parity. Setup: PARITY=2 with 0xA5; then PARITY=1 with 0xA5. Expected:
  - even parity bit = 0, odd parity bit = 1, sent after bit 7;
  - frame = 44 cycles.
- Case 3, burst with full FIFO. Setup: FIFO_DEPTH=4; hold s_valid with 6 words 0x01..0x06 while idle. Expected:
  - s_ready drops while fifo_count = 4;
  - all 6 frames go out in order with zero idle cycles between stop and start;
  - tx_busy stays high throughout.
- Case 4, two stop bits. Setup: STOP_BITS=2, DATA_WIDTH=7, push 0x7F. Expected: frame is 10 × 4 = 40 cycles, with the final 8 cycles high.
- Case 5, reset mid-frame. Setup: assert rst during data bit 3 of 0x00 with 2 words queued. Expected:
  - tx = 1 immediately, fifo_count = 0, tx_busy = 0;
  - no frame after release until a new push.
- Case 6, simultaneous push and pop. Setup: push exactly on the STOP→START pop cycle with fifo_count = 2. Expected: fifo_count stays 2 and the order is preserved.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and the future receiver.
//   PARITY_NONE/ODD/EVEN   parity mode encodings
//   DEFAULT_CLKS_PER_BIT   50 MHz / 115200 baud
//   tx_state_t             3-bit transmitter FSM state
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with first-word-fall-through read data. Full and empty
// come from read/write pointers carrying one extra wrap bit.
//   clk, rst   clock, asynchronous active-high reset
//   i_push     write i_data when not full
//   i_data     write data
//   i_pop      drop the head entry when not empty
//   o_data     head entry (undefined while empty)
//   o_full     DEPTH entries held
//   o_empty    no entries held
//   o_count    current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Same index with different wrap bits means the writer is a full lap ahead.
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  // A full FIFO refuses the write even when a pop frees a slot this cycle.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which
  // entries are valid, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter with baud divider, optional parity, 1 or 2 stop bits and
// an input FIFO. Queued words go out back-to-back with no idle gap.
//   clk         system clock
//   rst         asynchronous active-high reset
//   s_data      word to transmit
//   s_valid     s_data valid
//   s_ready     FIFO can accept (not full)
//   tx          serial line, idle high
//   tx_busy     high from frame start until the last stop bit ends with
//               the FIFO empty
//   tx_done     one-cycle pulse on the final clk of each frame
//   fifo_count  current FIFO occupancy
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = PARITY_NONE,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
    $error("uart_tx_fifo: DATA_WIDTH must be in 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two and at least 2");
  end

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W  = $clog2(DATA_WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]  STOP_LAST  = CNT_W'(STOP_BITS - 1);
  localparam bit                HAS_PARITY = (PARITY != PARITY_NONE);

  // FIFO interface
  logic [DATA_WIDTH-1:0] w_fifo_data;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_pop;

  // FSM and datapath
  tx_state_t             r_state;
  tx_state_t             w_state_next;
  logic [BAUD_W-1:0]     r_baud_cnt;
  logic [BAUD_W-1:0]     w_baud_d;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [CNT_W-1:0]      w_bit_cnt_d;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_d;
  logic                  r_parity;
  logic                  w_parity_d;
  logic                  w_bit_end;
  logic                  w_frame_end;

  // Registered outputs and their next values
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_tx_d;
  logic                  w_busy_d;
  logic                  w_done_d;

  uart_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (s_valid),
    .i_data  (s_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (fifo_count)
  );

  assign s_ready     = !w_fifo_full;
  assign w_bit_end   = (r_baud_cnt == BAUD_LAST);
  assign w_frame_end = (r_state == ST_STOP) && w_bit_end && (r_bit_cnt == STOP_LAST);
  // Pop when leaving IDLE, or at the end of a frame so the next start bit
  // follows the last stop bit with no idle cycle.
  assign w_pop       = !w_fifo_empty && ((r_state == ST_IDLE) || w_frame_end);

  // ---- FSM: state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // ---- FSM: next state ----
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (!w_fifo_empty) w_state_next = ST_START;
      ST_START:  if (w_bit_end) w_state_next = ST_DATA;
      ST_DATA:   if (w_bit_end && r_bit_cnt == DATA_LAST)
                   w_state_next = HAS_PARITY ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_bit_end) w_state_next = ST_STOP;
      ST_STOP:   if (w_frame_end) w_state_next = w_fifo_empty ? ST_IDLE : ST_START;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // ---- Datapath next values: baud counter, bit counter, shift register ----
  always_comb begin
    w_baud_d    = r_baud_cnt;
    w_bit_cnt_d = r_bit_cnt;
    w_shift_d   = r_shift;
    w_parity_d  = r_parity;
    if (w_pop) begin
      w_baud_d    = '0;
      w_bit_cnt_d = '0;
      w_shift_d   = w_fifo_data;
      w_parity_d  = (PARITY == PARITY_ODD) ? ~^w_fifo_data : ^w_fifo_data;
    end else if (r_state == ST_IDLE) begin
      w_baud_d = '0;
    end else begin
      w_baud_d = w_bit_end ? '0 : r_baud_cnt + BAUD_W'(1);
      if (w_bit_end) begin
        if (r_state == ST_DATA) begin
          // Bit 0 of the shift register is always the data bit on the line.
          w_shift_d   = r_shift >> 1;
          w_bit_cnt_d = (r_bit_cnt == DATA_LAST) ? '0 : r_bit_cnt + CNT_W'(1);
        end else if (r_state == ST_STOP) begin
          w_bit_cnt_d = r_bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  // ---- FSM: outputs, decoded from next state so they can be registered ----
  always_comb begin
    w_tx_d = 1'b1;
    unique case (w_state_next)
      ST_START:  w_tx_d = 1'b0;
      ST_DATA:   w_tx_d = w_shift_d[0];
      ST_PARITY: w_tx_d = r_parity;
      default:   w_tx_d = 1'b1;
    endcase
    w_busy_d = (w_state_next != ST_IDLE);
    // High for the last clk of the last stop bit; falls as the FSM leaves STOP.
    w_done_d = (w_state_next == ST_STOP) && (w_baud_d == BAUD_LAST) &&
               (w_bit_cnt_d == STOP_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_baud_cnt <= w_baud_d;
      r_bit_cnt  <= w_bit_cnt_d;
      r_shift    <= w_shift_d;
      r_parity   <= w_parity_d;
      r_tx       <= w_tx_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
    end
  end

  assign tx      = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Directed bench for uart_tx_fifo with CLKS_PER_BIT = 4. Four instances
// cover 8N1, 8E1, 8O1 and 7N2 framing; instance 0 also carries the burst,
// reset and push/pop scenarios. Expected line patterns are written out as
// {stop bits, parity, data, start} with bit 0 sent first, each bit
// expanded to 4 clk cycles.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] r_data [4];
  logic [3:0] r_valid;
  logic [3:0] w_ready;
  logic [3:0] w_tx;
  logic [3:0] w_busy;
  logic [3:0] w_done;
  logic [2:0] w_count [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_WIDTH(8), .STOP_BITS(1), .PARITY(PARITY_NONE),
                 .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) u_dut_8n1 (
    .clk(clk), .rst(rst), .s_data(r_data[0]), .s_valid(r_valid[0]),
    .s_ready(w_ready[0]), .tx(w_tx[0]), .tx_busy(w_busy[0]),
    .tx_done(w_done[0]), .fifo_count(w_count[0]));

  uart_tx_fifo #(.DATA_WIDTH(8), .STOP_BITS(1), .PARITY(PARITY_EVEN),
                 .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) u_dut_8e1 (
    .clk(clk), .rst(rst), .s_data(r_data[1]), .s_valid(r_valid[1]),
    .s_ready(w_ready[1]), .tx(w_tx[1]), .tx_busy(w_busy[1]),
    .tx_done(w_done[1]), .fifo_count(w_count[1]));

  uart_tx_fifo #(.DATA_WIDTH(8), .STOP_BITS(1), .PARITY(PARITY_ODD),
                 .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) u_dut_8o1 (
    .clk(clk), .rst(rst), .s_data(r_data[2]), .s_valid(r_valid[2]),
    .s_ready(w_ready[2]), .tx(w_tx[2]), .tx_busy(w_busy[2]),
    .tx_done(w_done[2]), .fifo_count(w_count[2]));

  uart_tx_fifo #(.DATA_WIDTH(7), .STOP_BITS(2), .PARITY(PARITY_NONE),
                 .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) u_dut_7n2 (
    .clk(clk), .rst(rst), .s_data(r_data[3][6:0]), .s_valid(r_valid[3]),
    .s_ready(w_ready[3]), .tx(w_tx[3]), .tx_busy(w_busy[3]),
    .tx_done(w_done[3]), .fifo_count(w_count[3]));

  // Each frame bit repeated CPB times, bit 0 first.
  function automatic logic [63:0] expand(input logic [15:0] bits, input int nbits);
    logic [63:0] v = '0;
    for (int b = 0; b < nbits; b++)
      for (int c = 0; c < CPB; c++)
        v[b * CPB + c] = bits[b];
    return v;
  endfunction

  function automatic logic [63:0] ones(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  // Record tx/busy/done at the next ncyc falling edges.
  task automatic capture(input int d, input int ncyc,
                         output logic [63:0] t, output logic [63:0] b,
                         output logic [63:0] dn);
    t = '0; b = '0; dn = '0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      t[i]  = w_tx[d];
      b[i]  = w_busy[d];
      dn[i] = w_done[d];
    end
  endtask

  // One-cycle push; returns 1 time unit after the accepting edge.
  task automatic send_one(input int d, input logic [7:0] data);
    @(negedge clk);
    r_data[d]  = data;
    r_valid[d] = 1'b1;
    @(posedge clk);
    #1 r_valid[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({w_tx[d], w_busy[d], w_done[d], w_ready[d], w_count[d]} !== 7'b1_0_0_1_000) begin
        failures++;
        $display("FAIL reset_dut%0d: got tx/busy/done/ready/count=%b required 1001000", d,
                 {w_tx[d], w_busy[d], w_done[d], w_ready[d], w_count[d]});
      end
    end
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({w_tx[0], w_busy[0], w_ready[0], w_count[0]} !== 6'b1_0_1_000) begin
      failures++;
      $display("FAIL reset_release: got %b required 101000",
               {w_tx[0], w_busy[0], w_ready[0], w_count[0]});
    end
  endtask

  // Single frame on instance d: latency, line pattern, busy, done, return to idle.
  task automatic test_single(input string name, input int d, input logic [7:0] data,
                             input logic [15:0] bits, input int nbits);
    logic [63:0] t, b, dn;
    int ncyc;
    ncyc = nbits * CPB;
    send_one(d, data);
    @(negedge clk);
    checks++;
    if ({w_tx[d], w_busy[d], w_count[d]} !== {1'b1, 1'b0, 3'd1}) begin
      failures++;
      $display("FAIL %s_latency: got tx/busy/count=%b required 10001", name,
               {w_tx[d], w_busy[d], w_count[d]});
    end
    capture(d, ncyc, t, b, dn);
    checks++;
    if (t !== expand(bits, nbits)) begin
      failures++;
      $display("FAIL %s_tx: got %h required %h", name, t, expand(bits, nbits));
    end
    checks++;
    if (b !== ones(ncyc)) begin
      failures++;
      $display("FAIL %s_busy: got %h required %h", name, b, ones(ncyc));
    end
    checks++;
    if (dn !== (64'd1 << (ncyc - 1))) begin
      failures++;
      $display("FAIL %s_done: got %h required %h", name, dn, 64'd1 << (ncyc - 1));
    end
    @(negedge clk);
    checks++;
    if ({w_tx[d], w_busy[d], w_done[d], w_count[d]} !== 6'b1_0_0_000) begin
      failures++;
      $display("FAIL %s_idle: got tx/busy/done/count=%b required 100000", name,
               {w_tx[d], w_busy[d], w_done[d], w_count[d]});
    end
  endtask

  task automatic test_frame_8n1();
    // 0xA5 -> line 0,1,0,1,0,0,1,0,1,1
    test_single("8n1", 0, 8'hA5, {1'b1, 8'hA5, 1'b0}, 10);
  endtask

  task automatic test_parity();
    // 0xA5 has four ones: even parity bit 0, odd parity bit 1.
    test_single("8e1", 1, 8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}, 11);
    test_single("8o1", 2, 8'hA5, {1'b1, 1'b1, 8'hA5, 1'b0}, 11);
  endtask

  task automatic test_two_stop();
    logic [63:0] t, b, dn;
    send_one(3, 8'h7F);
    @(negedge clk);
    capture(3, 40, t, b, dn);
    checks++;
    if (t !== expand({2'b11, 7'h7F, 1'b0}, 10)) begin
      failures++;
      $display("FAIL 7n2_tx: got %h required %h", t, expand({2'b11, 7'h7F, 1'b0}, 10));
    end
    checks++;
    if (t[39:32] !== 8'hFF || t[3:0] !== 4'h0) begin
      failures++;
      $display("FAIL 7n2_stop_tail: got tail=%h start=%h required tail=ff start=0",
               t[39:32], t[3:0]);
    end
    checks++;
    if (dn !== (64'd1 << 39) || b !== ones(40)) begin
      failures++;
      $display("FAIL 7n2_done_busy: got done=%h busy=%h required done=%h busy=%h",
               dn, b, 64'd1 << 39, ones(40));
    end
    @(negedge clk);
  endtask

  // s_valid held with 0x01..0x06 from idle. Edge E0 is the first accepting edge.
  task automatic test_back_to_back();
    logic [63:0] t, b, dn;
    int k, edge_n;
    int acc [6];
    logic ready_s;
    int exp_acc [6];
    exp_acc = '{0, 1, 2, 3, 4, 42};
    k = 0;
    edge_n = 0;
    @(negedge clk);
    fork
      begin
        r_data[0]  = 8'h01;
        r_valid[0] = 1'b1;
        while (k < 6 && edge_n < 300) begin
          if (edge_n == 5 || edge_n == 41) begin
            checks++;
            if ({w_ready[0], w_count[0]} !== {1'b0, 3'd4}) begin
              failures++;
              $display("FAIL burst_full_e%0d: got ready/count=%b required 0100", edge_n,
                       {w_ready[0], w_count[0]});
            end
          end
          if (edge_n == 42) begin
            checks++;
            if ({w_ready[0], w_count[0]} !== {1'b1, 3'd3}) begin
              failures++;
              $display("FAIL burst_reopen: got ready/count=%b required 1011",
                       {w_ready[0], w_count[0]});
            end
          end
          ready_s = w_ready[0];
          @(posedge clk);
          if (ready_s) begin
            acc[k] = edge_n;
            k++;
          end
          edge_n++;
          #1;
          if (k < 6) r_data[0] = 8'(k + 1);
          else       r_valid[0] = 1'b0;
        end
        r_valid[0] = 1'b0;
        checks++;
        if (k != 6) begin
          failures++;
          $display("FAIL burst_accept_timeout: got %0d words accepted required 6", k);
        end else begin
          for (int i = 0; i < 6; i++) begin
            checks++;
            if (acc[i] != exp_acc[i]) begin
              failures++;
              $display("FAIL burst_accept_edge%0d: got edge %0d required %0d", i, acc[i],
                       exp_acc[i]);
            end
          end
        end
      end
      begin
        @(negedge clk);
        for (int f = 0; f < 6; f++) begin
          capture(0, 40, t, b, dn);
          checks++;
          if (t !== expand({1'b1, 8'(f + 1), 1'b0}, 10) || b !== ones(40) ||
              dn !== (64'd1 << 39)) begin
            failures++;
            $display("FAIL burst_frame%0d: got tx=%h busy=%h done=%h required tx=%h busy=%h done=%h",
                     f, t, b, dn, expand({1'b1, 8'(f + 1), 1'b0}, 10), ones(40), 64'd1 << 39);
          end
        end
        @(negedge clk);
        checks++;
        if ({w_tx[0], w_busy[0], w_count[0]} !== {1'b1, 1'b0, 3'd0}) begin
          failures++;
          $display("FAIL burst_idle: got tx/busy/count=%b required 10000",
                   {w_tx[0], w_busy[0], w_count[0]});
        end
      end
    join
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] t, b, dn;
    logic stayed_idle;
    @(negedge clk);
    r_data[0]  = 8'h00;
    r_valid[0] = 1'b1;
    repeat (3) @(posedge clk);         // E0, E1 (frame starts), E2
    #1 r_valid[0] = 1'b0;
    repeat (16) @(posedge clk);        // E18
    @(negedge clk);                    // middle of frame cycle 18 = data bit 3
    checks++;
    if ({w_tx[0], w_busy[0], w_count[0]} !== {1'b0, 1'b1, 3'd2}) begin
      failures++;
      $display("FAIL midframe_before: got tx/busy/count=%b required 01010",
               {w_tx[0], w_busy[0], w_count[0]});
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({w_tx[0], w_busy[0], w_done[0], w_ready[0], w_count[0]} !== 7'b1_0_0_1_000) begin
      failures++;
      $display("FAIL midframe_reset: got tx/busy/done/ready/count=%b required 1001000",
               {w_tx[0], w_busy[0], w_done[0], w_ready[0], w_count[0]});
    end
    @(negedge clk) rst = 1'b0;
    stayed_idle = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (w_tx[0] !== 1'b1 || w_busy[0] !== 1'b0) stayed_idle = 1'b0;
    end
    checks++;
    if (stayed_idle !== 1'b1) begin
      failures++;
      $display("FAIL midframe_quiet: got a frame after reset without a push");
    end
    send_one(0, 8'h3C);
    @(negedge clk);
    capture(0, 40, t, b, dn);
    checks++;
    if (t !== expand({1'b1, 8'h3C, 1'b0}, 10)) begin
      failures++;
      $display("FAIL midframe_resume: got %h required %h", t, expand({1'b1, 8'h3C, 1'b0}, 10));
    end
    @(negedge clk);
  endtask

  // Push lands on the STOP->START pop edge (E41) while two words are queued.
  task automatic test_push_pop();
    logic [63:0] t, b, dn;
    logic [7:0] words [4];
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    @(negedge clk);
    fork
      begin
        r_data[0]  = 8'h11;
        r_valid[0] = 1'b1;
        @(posedge clk);                // E0
        #1 r_data[0] = 8'h22;
        @(posedge clk);                // E1: pop 0x11, push 0x22
        #1 r_data[0] = 8'h33;
        @(posedge clk);                // E2
        #1 r_valid[0] = 1'b0;
        repeat (38) @(posedge clk);    // E40
        #1;
        r_data[0]  = 8'h44;
        r_valid[0] = 1'b1;
        checks++;
        if ({w_ready[0], w_count[0]} !== {1'b1, 3'd2}) begin
          failures++;
          $display("FAIL pushpop_before: got ready/count=%b required 1010",
                   {w_ready[0], w_count[0]});
        end
        @(posedge clk);                // E41: pop 0x22 and push 0x44
        #1 r_valid[0] = 1'b0;
        checks++;
        if (w_count[0] !== 3'd2) begin
          failures++;
          $display("FAIL pushpop_count: got %0d required 2", w_count[0]);
        end
      end
      begin
        @(negedge clk);
        for (int f = 0; f < 4; f++) begin
          capture(0, 40, t, b, dn);
          checks++;
          if (t !== expand({1'b1, words[f], 1'b0}, 10) || b !== ones(40) ||
              dn !== (64'd1 << 39)) begin
            failures++;
            $display("FAIL pushpop_frame%0d: got tx=%h busy=%h done=%h required tx=%h",
                     f, t, b, dn, expand({1'b1, words[f], 1'b0}, 10));
          end
        end
        @(negedge clk);
        checks++;
        if ({w_busy[0], w_count[0]} !== {1'b0, 3'd0}) begin
          failures++;
          $display("FAIL pushpop_idle: got busy/count=%b required 0000",
                   {w_busy[0], w_count[0]});
        end
      end
    join
  endtask

  initial begin
    r_valid = '0;
    for (int i = 0; i < 4; i++) r_data[i] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_frame_8n1();
    test_parity();
    test_two_stop();
    test_back_to_back();
    test_reset_mid_frame();
    test_push_pop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
